// File: rtl/fp_posit_mac_pkg.sv
// Shared types and limits for the posit MAC lane sequencer.
package fp_posit_mac_pkg;

    localparam int PREC_W    = 4;
    localparam int EXP_W     = 5;
    localparam int W_MAX_DEF = 8;
    localparam int PREC_MIN  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_FETCH,
        ST_SHIFT,
        ST_WAIT,
        ST_OUT
    } state_e;

    function automatic logic prec_legal(input logic [PREC_W-1:0] p, input int w_max);
        return (int'(p) >= PREC_MIN) && (int'(p) <= w_max);
    endfunction

endpackage

// File: rtl/fp_posit_w_serializer.sv
// Holds one posit weight word and presents it MSB-first, one bit per shift.
module fp_posit_w_serializer
    import fp_posit_mac_pkg::*;
#(
    parameter int W_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [W_MAX-1:0]  word_i,
    input  logic [PREC_W-1:0] prec_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic              last_o
);

    localparam int IDX_W = (W_MAX > 1) ? $clog2(W_MAX) : 1;

    logic [W_MAX-1:0] word_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= IDX_W'(prec_i - PREC_W'(1));
        end else if (shift_i && !last_o) begin
            idx_q  <= idx_q - IDX_W'(1);
        end
    end

    assign bit_o  = word_q[idx_q];
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/fp_posit_mac_seq.sv
// Sequencer for one bit-serial posit MAC lane: streams weights MSB-first and chains the accumulator.
// Optional ZERO_SKIP_EN: zero weight words bypass SHIFT/WAIT and leave the accumulator unchanged.
module fp_posit_mac_seq
    import fp_posit_mac_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int W_MAX     = W_MAX_DEF,
    parameter int LEN_WIDTH = 10,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_start_i,
    input  logic                 cfg_abort_i,
    input  logic [LEN_WIDTH-1:0] cfg_len_i,
    input  logic [PREC_W-1:0]    cfg_precision_i,
    input  logic [EXP_W-1:0]     cfg_exp_min_i,
    input  logic [ACC_WIDTH-1:0] cfg_acc_init_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ACT_WIDTH-1:0] in_act_i,
    input  logic [W_MAX-1:0]     in_w_i,
    output logic                 mac_valid_o,
    output logic                 mac_set_o,
    output logic                 mac_w_o,
    output logic [ACT_WIDTH-1:0] mac_act_o,
    output logic [PREC_W-1:0]    mac_precision_o,
    output logic [EXP_W-1:0]     mac_exp_min_o,
    output logic [ACC_WIDTH-1:0] mac_acc_o,
    input  logic                 mac_done_i,
    input  logic [ACC_WIDTH-1:0] mac_acc_out_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_acc_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [LEN_WIDTH-1:0] elem_q, len_q, elem_nxt;
    logic [TO_W-1:0]      wait_q;
    logic [PREC_W-1:0]    prec_q;
    logic [EXP_W-1:0]     exp_min_q;
    logic [ACT_WIDTH-1:0] act_q;
    logic                 err_q, done_q;
    logic                 cfg_ok, accept, done_rise, skip_zero;
    logic                 ser_bit, ser_last;

    assign cfg_ok    = (cfg_len_i != '0) && prec_legal(cfg_precision_i, W_MAX);
    assign in_ready_o = (state_q == ST_FETCH) && !cfg_abort_i;
    assign accept    = in_ready_o && in_valid_i;
    // A level still high from the previous element must not count as a new completion.
    assign done_rise = mac_done_i && !done_q;
    assign elem_nxt  = elem_q + LEN_WIDTH'(1);

`ifdef ZERO_SKIP_EN
    assign skip_zero = (in_w_i == '0);
`else
    assign skip_zero = 1'b0;
`endif

    fp_posit_w_serializer #(.W_MAX(W_MAX)) u_ser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept),
        .word_i  (in_w_i),
        .prec_i  (prec_q),
        .shift_i (state_q == ST_SHIFT),
        .bit_o   (ser_bit),
        .last_o  (ser_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            elem_q    <= '0;
            len_q     <= '0;
            wait_q    <= '0;
            prec_q    <= '0;
            exp_min_q <= '0;
            act_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= mac_done_i;
            if (cfg_abort_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (cfg_start_i) begin
                        err_q <= !cfg_ok;
                        if (cfg_ok) begin
                            len_q     <= cfg_len_i;
                            prec_q    <= cfg_precision_i;
                            exp_min_q <= cfg_exp_min_i;
                            acc_q     <= cfg_acc_init_i;
                            elem_q    <= '0;
                            state_q   <= ST_SET;
                        end
                    end
                    ST_SET: state_q <= ST_FETCH;
                    ST_FETCH: if (in_valid_i) begin
                        act_q <= in_act_i;
                        if (skip_zero) begin
                            elem_q  <= elem_nxt;
                            state_q <= (elem_nxt == len_q) ? ST_OUT : ST_FETCH;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: if (ser_last) begin
                        wait_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (done_rise) begin
                            acc_q   <= mac_acc_out_i;
                            elem_q  <= elem_nxt;
                            state_q <= (elem_nxt == len_q) ? ST_OUT : ST_FETCH;
                        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            wait_q  <= wait_q + TO_W'(1);
                        end
                    end
                    ST_OUT: if (out_ready_i) state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mac_valid_o     = (state_q == ST_SHIFT);
    assign mac_set_o       = (state_q == ST_SET);
    assign mac_w_o         = (state_q == ST_SHIFT) && ser_bit;
    assign mac_act_o       = act_q;
    assign mac_precision_o = prec_q;
    assign mac_exp_min_o   = exp_min_q;
    assign mac_acc_o       = acc_q;
    assign out_valid_o     = (state_q == ST_OUT);
    assign out_acc_o       = acc_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_fp_posit_mac_seq.sv
// Directed bench for fp_posit_mac_seq with a small behavioural MAC that returns acc+1.
module tb_fp_posit_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [9:0]  cfg_len = '0;
    logic [3:0]  cfg_precision = '0;
    logic [4:0]  cfg_exp_min = '0;
    logic [31:0] cfg_acc_init = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_act = '0;
    logic [7:0]  in_w = '0;
    logic        mac_valid, mac_set, mac_w;
    logic [15:0] mac_act;
    logic [3:0]  mac_precision;
    logic [4:0]  mac_exp_min;
    logic [31:0] mac_acc;
    logic        mac_done = 1'b0;
    logic [31:0] mac_acc_out = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_acc;
    logic        busy, err;

    int tests = 0, fails = 0;
    int valid_cnt = 0, set_cnt = 0, bursts = 0, pend = 0, mcnt = 0;
    logic [15:0] bits_seen = '0;
    logic        prev_valid = 1'b0;
    bit          mac_en = 1'b1;
    logic [31:0] acc_log[$];
    int          snap;

    always #5 clk = ~clk;

    fp_posit_mac_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort), .cfg_len_i(cfg_len),
        .cfg_precision_i(cfg_precision), .cfg_exp_min_i(cfg_exp_min), .cfg_acc_init_i(cfg_acc_init),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_act_i(in_act), .in_w_i(in_w),
        .mac_valid_o(mac_valid), .mac_set_o(mac_set), .mac_w_o(mac_w), .mac_act_o(mac_act),
        .mac_precision_o(mac_precision), .mac_exp_min_o(mac_exp_min), .mac_acc_o(mac_acc),
        .mac_done_i(mac_done), .mac_acc_out_i(mac_acc_out),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_acc_o(out_acc),
        .busy_o(busy), .err_o(err)
    );

    // MAC model: done pulses two cycles after the last serial bit, result = acc + 1.
    always @(posedge clk) begin
        #1;
        mac_done = 1'b0;
        if (mac_valid) begin
            valid_cnt++;
            bits_seen = {bits_seen[14:0], mac_w};
            if (!prev_valid) begin
                bursts++;
                acc_log.push_back(mac_acc);
            end
            pend = 1;
            mcnt = 0;
        end else if (pend != 0 && mac_en) begin
            mcnt++;
            if (mcnt == 2) begin
                mac_done    = 1'b1;
                mac_acc_out = mac_acc + 32'd1;
                pend        = 0;
            end
        end else begin
            pend = 0;
        end
        if (mac_set) set_cnt++;
        prev_valid = mac_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [9:0] len, input logic [3:0] prec, input logic [31:0] init,
                         input logic [4:0] emin);
        @(negedge clk);
        cfg_len = len; cfg_precision = prec; cfg_acc_init = init; cfg_exp_min = emin;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] act, input logic [7:0] w);
        in_act = act; in_w = w; in_valid = 1'b1;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_shift();
        for (int i = 0; i < 40 && mac_valid; i++) @(negedge clk);
    endtask

    task automatic finish_out(input logic [31:0] exp_acc);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_acc", out_acc, exp_acc);
        @(negedge clk);
        chk("out_hold", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_clear", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic clr();
        valid_cnt = 0; bursts = 0; bits_seen = '0; acc_log.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mac_acc", mac_acc, 32'd0);
        rst_n = 1'b1;

        // Single element, precision 4, weight 0101 -> bits 0,1,0,1
        clr();
        start(10'd1, 4'd4, 32'd0, 5'd3);
        feed(16'h3C00, 8'h05);
        chk("t1_act", {16'd0, mac_act}, 32'h3C00);
        chk("t1_prec", {28'd0, mac_precision}, 32'd4);
        chk("t1_emin", {27'd0, mac_exp_min}, 32'd3);
        finish_out(32'd1);
        chk("t1_bits", {28'd0, bits_seen[3:0]}, 32'h5);
        chk("t1_vcnt", valid_cnt, 32'd4);
        chk("t1_bursts", bursts, 32'd1);
        chk("t1_sets", set_cnt, 32'd1);

        // Three elements, precision 2 (minimum), acc chain 2 -> 3 -> 4 -> 5
        clr();
        start(10'd3, 4'd2, 32'd2, 5'd0);
        feed(16'h1111, 8'h01);
        in_act = 16'hBEEF;
        chk("t2_act_hold", {16'd0, mac_act}, 32'h1111);
        feed(16'h2222, 8'h02);
        feed(16'h3333, 8'h03);
        finish_out(32'd5);
        chk("t2_nlog", acc_log.size(), 32'd3);
        chk("t2_acc0", acc_log[0], 32'd2);
        chk("t2_acc1", acc_log[1], 32'd3);
        chk("t2_acc2", acc_log[2], 32'd4);
        chk("t2_vcnt", valid_cnt, 32'd6);
        chk("t2_bits", {26'd0, bits_seen[5:0]}, 32'h1B);

        // Illegal configs: precision above W_MAX, zero length
        snap = set_cnt;
        start(10'd1, 4'd9, 32'd0, 5'd0);
        chk("t3_err_p9", {31'd0, err}, 32'd1);
        chk("t3_busy_p9", {31'd0, busy}, 32'd0);
        start(10'd0, 4'd4, 32'd0, 5'd0);
        chk("t3_err_len0", {31'd0, err}, 32'd1);
        chk("t3_no_set", set_cnt, snap);

        // Maximum precision 8; legal start clears err
        clr();
        start(10'd1, 4'd8, 32'd10, 5'd0);
        chk("t4_err_clr", {31'd0, err}, 32'd0);
        feed(16'h0001, 8'hA5);
        finish_out(32'd11);
        chk("t4_bits", {24'd0, bits_seen[7:0]}, 32'hA5);
        chk("t4_vcnt", valid_cnt, 32'd8);

        // WAIT timeout after exactly 64 cycles
        mac_en = 1'b0;
        start(10'd1, 4'd4, 32'd0, 5'd0);
        feed(16'h0002, 8'h07);
        drain_shift();
        repeat (63) @(negedge clk);
        chk("t5_busy_63", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t5_busy_64", {31'd0, busy}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_no_out", {31'd0, out_valid}, 32'd0);
        mac_en = 1'b1;

        // Abort in SHIFT cycle 2
        start(10'd1, 4'd4, 32'd0, 5'd0);
        chk("t6_err_clr", {31'd0, err}, 32'd0);
        feed(16'h4444, 8'h0F);
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("t6_abort_valid", {31'd0, mac_valid}, 32'd0);
        chk("t6_abort_busy", {31'd0, busy}, 32'd0);

        // Abort in FETCH beats a pending operand
        start(10'd1, 4'd4, 32'd0, 5'd0);
        in_act = 16'h5555; in_w = 8'h03; in_valid = 1'b1; cfg_abort = 1'b1;
        chk("t7_ready_abort", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        cfg_abort = 1'b0; in_valid = 1'b0;
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_act_kept", {16'd0, mac_act}, 32'h4444);

        // Reset mid-WAIT returns all outputs to zero
        mac_en = 1'b0;
        start(10'd1, 4'd4, 32'd7, 5'd9);
        feed(16'h6666, 8'h09);
        drain_shift();
        chk("t8_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_busy", {31'd0, busy}, 32'd0);
        chk("t8_acc", mac_acc, 32'd0);
        chk("t8_act", {16'd0, mac_act}, 32'd0);
        chk("t8_prec", {28'd0, mac_precision}, 32'd0);
        chk("t8_emin", {27'd0, mac_exp_min}, 32'd0);
        chk("t8_out", out_acc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mac_en = 1'b1;

        // Zero weight in second slot
        clr();
        start(10'd2, 4'd4, 32'd3, 5'd0);
        feed(16'h7777, 8'h06);
        feed(16'h8888, 8'h00);
`ifdef ZERO_SKIP_EN
        finish_out(32'd4);
        chk("t9_bursts", bursts, 32'd1);
`else
        finish_out(32'd5);
        chk("t9_bursts", bursts, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
